// File: rtl/rmii_rx.sv
// rmii_rx: 100 Mbps RMII receive front end for one L2 switch port.
//   Turns RXD1:RXD0 dibits (qualified by CRS_DV) into bytes, strips the
//   preamble/SFD, checks frame length and CRC-32, and pushes bytes into the
//   port RX FIFO. The last byte of each frame carries EOD=1 and ERR says
//   whether the fabric should discard it.
// Ports:
//   REF_CLK, rst           50 MHz PHY clock, synchronous active-high reset
//   RXD0, RXD1, CRS_DV     RMII receive dibit and data-valid
//   fifo_full, fifo_afull  RX FIFO back-pressure
//   fifo_din/_wren/_EOD_in/_ERR_in  FIFO write port
//   succ/fail_rx_count_gray         gray-coded good / bad-or-dropped frame counts
module rmii_rx #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522
) (
  input  logic        REF_CLK,
  input  logic        rst,
  input  logic        RXD0,
  input  logic        RXD1,
  input  logic        CRS_DV,
  input  logic        fifo_full,
  input  logic        fifo_afull,
  output logic [7:0]  fifo_din,
  output logic        fifo_wren,
  output logic        fifo_EOD_in,
  output logic        fifo_ERR_in,
  output logic [15:0] succ_rx_count_gray,
  output logic [15:0] fail_rx_count_gray
);

  localparam int                CNT_W       = $clog2(MAX_FRAME + 2);
  localparam logic [CNT_W-1:0]  MIN_LEN     = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0]  MAX_LEN     = CNT_W'(MAX_FRAME);
  localparam logic [31:0]       CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_BODY, S_FEND, S_ABORT, S_DROP, S_END
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] din;
    logic       eod;
    logic       err;
  } wr_req_t;

  state_t            state, state_n;
  wr_req_t           wr;
  logic              init, shift, drop_hit;
  logic [1:0]        dibit, phase;
  logic [5:0]        sh;          // previous three dibits of the byte in flight
  logic [7:0]        byte_new, held, last_byte;
  logic              have_held, crs_gone, frame_err;
  logic [CNT_W-1:0]  byte_cnt;
  logic [31:0]       crc;
  logic [15:0]       succ_bin, fail_bin;

  // Reflected CRC-32, one byte LSB-first, no final inversion so a good
  // frame leaves the fixed residue in the register after the FCS.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign dibit     = {RXD1, RXD0};
  assign byte_new  = {dibit, sh};
  assign last_byte = have_held ? held : 8'h00;
  assign frame_err = (phase != 2'd0) || (byte_cnt < MIN_LEN) || (crc != CRC_RESIDUE);

  always_ff @(posedge REF_CLK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    wr       = '0;
    init     = 1'b0;
    shift    = 1'b0;
    drop_hit = 1'b0;
    case (state)
      S_IDLE: if (CRS_DV && dibit == 2'b01) state_n = S_PRE;
      S_PRE: begin
        if (CRS_DV && dibit == 2'b01) state_n = S_PRE;
        else if (CRS_DV && dibit == 2'b11) begin
          // No room for a worst-case frame: swallow it without writing.
          if (fifo_afull) begin
            state_n  = S_DROP;
            drop_hit = 1'b1;
          end else begin
            state_n = S_BODY;
            init    = 1'b1;
          end
        end else state_n = S_IDLE;
      end
      S_BODY: begin
        if (CRS_DV) begin
          shift = 1'b1;
          if (phase == 2'd3) begin
            // Byte N done: release byte N-1 so the final byte stays held
            // for the EOD tag.
            if (have_held) begin
              if (fifo_full) state_n = S_ABORT;
              else begin
                wr.vld = 1'b1;
                wr.din = held;
              end
            end
            if (byte_cnt == MAX_LEN) state_n = S_ABORT;
          end
        end else if (fifo_full) state_n = S_FEND;
        else begin
          wr.vld  = 1'b1;
          wr.din  = last_byte;
          wr.eod  = 1'b1;
          wr.err  = frame_err;
          state_n = S_END;
        end
      end
      // EOD write stalled by a full FIFO; frame state is frozen, CRS_DV ignored.
      S_FEND: begin
        if (!fifo_full) begin
          wr.vld  = 1'b1;
          wr.din  = last_byte;
          wr.eod  = 1'b1;
          wr.err  = frame_err;
          state_n = S_END;
        end
      end
      S_ABORT: begin
        if ((!CRS_DV || crs_gone) && !fifo_full) begin
          wr.vld  = 1'b1;
          wr.din  = 8'h00;
          wr.eod  = 1'b1;
          wr.err  = 1'b1;
          state_n = S_END;
        end
      end
      S_DROP:  if (!CRS_DV) state_n = S_END;
      S_END:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge REF_CLK) begin
    if (rst) begin
      fifo_wren          <= 1'b0;
      fifo_din           <= 8'h00;
      fifo_EOD_in        <= 1'b0;
      fifo_ERR_in        <= 1'b0;
      phase              <= 2'd0;
      sh                 <= '0;
      held               <= 8'h00;
      have_held          <= 1'b0;
      crs_gone           <= 1'b0;
      byte_cnt           <= '0;
      crc                <= 32'hFFFFFFFF;
      succ_bin           <= 16'h0000;
      fail_bin           <= 16'h0000;
      succ_rx_count_gray <= 16'h0000;
      fail_rx_count_gray <= 16'h0000;
    end else begin
      fifo_wren   <= wr.vld;
      fifo_din    <= wr.din;
      fifo_EOD_in <= wr.eod;
      fifo_ERR_in <= wr.err;

      if (init) begin
        phase     <= 2'd0;
        have_held <= 1'b0;
        crs_gone  <= 1'b0;
        byte_cnt  <= '0;
        crc       <= 32'hFFFFFFFF;
      end
      if (shift) begin
        sh    <= byte_new[7:2];
        phase <= phase + 2'd1;
        if (phase == 2'd3) begin
          held      <= byte_new;
          have_held <= 1'b1;
          crc       <= crc_byte(crc, byte_new);
          byte_cnt  <= byte_cnt + CNT_W'(1);
        end
      end
      if (state == S_ABORT && !CRS_DV) crs_gone <= 1'b1;

      // Counters only move on an event; both wrap naturally at 16 bits.
      if (wr.vld && wr.eod && !wr.err)            succ_bin <= succ_bin + 16'd1;
      if ((wr.vld && wr.eod && wr.err) || drop_hit) fail_bin <= fail_bin + 16'd1;
      succ_rx_count_gray <= succ_bin ^ (succ_bin >> 1);
      fail_rx_count_gray <= fail_bin ^ (fail_bin >> 1);
    end
  end

endmodule

// File: tb/tb_rmii_rx.sv
// Scoreboard bench for rmii_rx: stimulus tasks push the expected FIFO
// writes, an independent monitor pops and compares on every fifo_wren.
module tb_rmii_rx;

  logic        REF_CLK = 1'b0;
  logic        rst, RXD0, RXD1, CRS_DV, fifo_full, fifo_afull;
  logic [7:0]  fifo_din;
  logic        fifo_wren, fifo_EOD_in, fifo_ERR_in;
  logic [15:0] succ_rx_count_gray, fail_rx_count_gray;

  always #10 REF_CLK = ~REF_CLK;

  rmii_rx #(.MIN_FRAME(64), .MAX_FRAME(1522)) dut (
    .REF_CLK(REF_CLK), .rst(rst), .RXD0(RXD0), .RXD1(RXD1), .CRS_DV(CRS_DV),
    .fifo_full(fifo_full), .fifo_afull(fifo_afull), .fifo_din(fifo_din),
    .fifo_wren(fifo_wren), .fifo_EOD_in(fifo_EOD_in), .fifo_ERR_in(fifo_ERR_in),
    .succ_rx_count_gray(succ_rx_count_gray), .fail_rx_count_gray(fail_rx_count_gray)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       eod;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  logic [7:0]  fr[0:1599];
  logic [15:0] exp_succ = 16'h0;
  logic [15:0] exp_fail = 16'h0;

  function automatic logic [15:0] gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bitwise reference CRC over fr[0..n-1], returns the FCS value.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fr[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  // Monitor: every DUT write must match the head of the expected queue.
  always @(negedge REF_CLK) begin
    if (fifo_wren === 1'b1) begin
      exp_t e;
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got din=%h eod=%b err=%b, none expected",
                 fifo_din, fifo_EOD_in, fifo_ERR_in);
      end else begin
        e = exp_q.pop_front();
        if (fifo_din !== e.d || fifo_EOD_in !== e.eod || fifo_ERR_in !== e.err) begin
          errors++;
          $display("FAIL write_%0d: got din=%h eod=%b err=%b, expected din=%h eod=%b err=%b",
                   wr_seen, fifo_din, fifo_EOD_in, fifo_ERR_in, e.d, e.eod, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic dib(input logic [1:0] d, input logic full);
    @(negedge REF_CLK);
    CRS_DV    = 1'b1;
    RXD1      = d[1];
    RXD0      = d[0];
    fifo_full = full;
  endtask

  task automatic idle(input int n, input logic full);
    for (int i = 0; i < n; i++) begin
      @(negedge REF_CLK);
      CRS_DV    = 1'b0;
      RXD1      = 1'b0;
      RXD0      = 1'b0;
      fifo_full = full;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) dib(b[2*k +: 2], 1'b0);
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  // n total bytes: n-4 payload bytes followed by the FCS, LSB byte first.
  task automatic make_frame(input int n, input int seed);
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) fr[i] = 8'((i * 37 + seed) & 255);
    f = fcs_of(n - 4);
    fr[n-4] = f[7:0];
    fr[n-3] = f[15:8];
    fr[n-2] = f[23:16];
    fr[n-1] = f[31:24];
  endtask

  task automatic exp_frame(input int n, input logic err);
    for (int i = 0; i < n - 1; i++) exp_q.push_back({fr[i], 1'b0, 1'b0});
    exp_q.push_back({fr[n-1], 1'b1, err});
  endtask

  task automatic send_frame(input int n);
    preamble();
    for (int i = 0; i < n; i++) send_byte(fr[i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge REF_CLK);
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_cnt(input string name);
    idle(4, 1'b0);
    chk({name, "_succ"}, {16'h0, succ_rx_count_gray}, {16'h0, gray(exp_succ)});
    chk({name, "_fail"}, {16'h0, fail_rx_count_gray}, {16'h0, gray(exp_fail)});
  endtask

  initial begin
    rst = 1'b1; RXD0 = 1'b0; RXD1 = 1'b0; CRS_DV = 1'b0;
    fifo_full = 1'b0; fifo_afull = 1'b0;
    repeat (3) @(negedge REF_CLK);
    chk("reset_wren", {31'h0, fifo_wren}, 32'h0);
    chk("reset_din", {24'h0, fifo_din}, 32'h0);
    chk("reset_eod_err", {30'h0, fifo_EOD_in, fifo_ERR_in}, 32'h0);
    chk("reset_succ", {16'h0, succ_rx_count_gray}, 32'h0);
    chk("reset_fail", {16'h0, fail_rx_count_gray}, 32'h0);
    rst = 1'b0;
    idle(3, 1'b0);

    // Good 64-byte frame.
    make_frame(64, 5);
    exp_frame(64, 1'b0);
    send_frame(64); idle(6, 1'b0);
    drain("good64"); exp_succ++; chk_cnt("good64");

    // Corrupted last FCS byte.
    make_frame(64, 9);
    fr[63] = fr[63] ^ 8'h01;
    exp_frame(64, 1'b1);
    send_frame(64); idle(6, 1'b0);
    drain("badfcs"); exp_fail++; chk_cnt("badfcs");

    // Runt with valid FCS.
    make_frame(60, 17);
    exp_frame(60, 1'b1);
    send_frame(60); idle(6, 1'b0);
    drain("runt"); exp_fail++; chk_cnt("runt");

    // 1523 bytes: 1522 written, then a 0x00 error terminator.
    make_frame(1523, 3);
    for (int i = 0; i < 1522; i++) exp_q.push_back({fr[i], 1'b0, 1'b0});
    exp_q.push_back({8'h00, 1'b1, 1'b1});
    send_frame(1523); idle(6, 1'b0);
    drain("long"); exp_fail++; chk_cnt("long");

    // Almost-full at SFD: frame dropped, nothing written.
    make_frame(64, 21);
    fifo_afull = 1'b1;
    send_frame(64);
    fifo_afull = 1'b0;
    idle(6, 1'b0);
    drain("drop"); exp_fail++; chk_cnt("drop");

    // FIFO full across completion of byte 20: bytes 1..18 land, byte 19 lost.
    make_frame(64, 33);
    for (int i = 0; i < 18; i++) exp_q.push_back({fr[i], 1'b0, 1'b0});
    exp_q.push_back({8'h00, 1'b1, 1'b1});
    preamble();
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) dib(fr[i][2*k +: 2], (i == 19) && (k >= 1));
    idle(6, 1'b0);
    drain("overflow"); exp_fail++; chk_cnt("overflow");

    // FIFO full at frame end: EOD write held, frame still good.
    make_frame(64, 41);
    exp_frame(64, 1'b0);
    send_frame(64); idle(3, 1'b1); idle(6, 1'b0);
    drain("eod_hold"); exp_succ++; chk_cnt("eod_hold");

    // Two dribble dibits after a good frame.
    make_frame(64, 55);
    exp_frame(64, 1'b1);
    send_frame(64);
    dib(2'b10, 1'b0); dib(2'b10, 1'b0);
    idle(6, 1'b0);
    drain("dribble"); exp_fail++; chk_cnt("dribble");

    // Preload the good counter to 0xFFFF, then wrap it with one frame.
    force dut.succ_bin = 16'hFFFF;
    idle(2, 1'b0);
    release dut.succ_bin;
    exp_succ = 16'hFFFF;
    chk_cnt("preload");
    make_frame(64, 77);
    exp_frame(64, 1'b0);
    send_frame(64); idle(6, 1'b0);
    drain("wrap"); exp_succ = 16'h0000; chk_cnt("wrap");

    // Reset mid-frame at byte 30: byte 29 is the last write, no EOD.
    make_frame(64, 91);
    for (int i = 0; i < 29; i++) exp_q.push_back({fr[i], 1'b0, 1'b0});
    preamble();
    for (int i = 0; i < 30; i++) send_byte(fr[i]);
    @(negedge REF_CLK);
    rst = 1'b1; CRS_DV = 1'b0; RXD0 = 1'b0; RXD1 = 1'b0;
    @(negedge REF_CLK);
    rst = 1'b0;
    chk("midrst_wren", {31'h0, fifo_wren}, 32'h0);
    chk("midrst_din_eod_err", {22'h0, fifo_din, fifo_EOD_in, fifo_ERR_in}, 32'h0);
    exp_succ = 16'h0; exp_fail = 16'h0;
    idle(6, 1'b0);
    drain("midrst"); chk_cnt("midrst");

    make_frame(64, 123);
    exp_frame(64, 1'b0);
    send_frame(64); idle(6, 1'b0);
    drain("after_rst"); exp_succ++; chk_cnt("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
